// File: rtl/present_pkg.sv
// Shared PRESENT definitions: S-box tables, substitution and permutation
// layers (forward and inverse), core FSM state type and block/key widths.
package present_pkg;

  localparam int BLOCK_W = 64;
  localparam int KEY_W   = 128;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Forward 4-bit PRESENT S-box.
  function automatic logic [3:0] sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'hC;  4'h1: y = 4'h5;  4'h2: y = 4'h6;  4'h3: y = 4'hB;
      4'h4: y = 4'h9;  4'h5: y = 4'h0;  4'h6: y = 4'hA;  4'h7: y = 4'hD;
      4'h8: y = 4'h3;  4'h9: y = 4'hE;  4'hA: y = 4'hF;  4'hB: y = 4'h8;
      4'hC: y = 4'h4;  4'hD: y = 4'h7;  4'hE: y = 4'h1;  default: y = 4'h2;
    endcase
    return y;
  endfunction

  // Inverse 4-bit PRESENT S-box, used by the decrypt core.
  function automatic logic [3:0] inv_sbox4(input logic [3:0] x);
    logic [3:0] y;
    case (x)
      4'h0: y = 4'h5;  4'h1: y = 4'hE;  4'h2: y = 4'hF;  4'h3: y = 4'h8;
      4'h4: y = 4'hC;  4'h5: y = 4'h1;  4'h6: y = 4'h2;  4'h7: y = 4'hD;
      4'h8: y = 4'hB;  4'h9: y = 4'h4;  4'hA: y = 4'h6;  4'hB: y = 4'h3;
      4'hC: y = 4'h0;  4'hD: y = 4'h7;  4'hE: y = 4'h9;  default: y = 4'hA;
    endcase
    return y;
  endfunction

  // S-box applied to all 16 nibbles in parallel.
  function automatic logic [BLOCK_W-1:0] sbox_layer(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = sbox4(d[4*n +: 4]);
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_sbox_layer(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] r;
    for (int n = 0; n < 16; n++) r[4*n +: 4] = inv_sbox4(d[4*n +: 4]);
    return r;
  endfunction

  // Bit i moves to bit (16*i) mod 63; bit 63 stays in place.
  function automatic logic [BLOCK_W-1:0] p_layer(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] r;
    r     = '0;
    r[63] = d[63];
    for (int i = 0; i < 63; i++) r[6'((16 * i) % 63)] = d[i];
    return r;
  endfunction

  function automatic logic [BLOCK_W-1:0] inv_p_layer(input logic [BLOCK_W-1:0] d);
    logic [BLOCK_W-1:0] r;
    r     = '0;
    r[63] = d[63];
    for (int i = 0; i < 63; i++) r[i] = d[6'((16 * i) % 63)];
    return r;
  endfunction

endpackage

// File: rtl/present_key_schedule_128.sv
// PRESENT-128 key register: loads the cipher key, then advances one round
// key per step using the round counter supplied by the core.
module present_key_schedule_128
  import present_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [KEY_W-1:0]   key_i,
  input  logic [4:0]         rc_i,
  output logic [BLOCK_W-1:0] round_key_o
);

  logic [KEY_W-1:0] k_q, k_d;

  // Rotate left by 61, substitute the top two nibbles, mix in the counter.
  function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                  input logic [4:0]       rc);
    logic [KEY_W-1:0] r;
    r          = {k[66:0], k[127:67]};
    r[127:124] = sbox4(r[127:124]);
    r[123:120] = sbox4(r[123:120]);
    r[66:62]   = r[66:62] ^ rc;
    return r;
  endfunction

  // Next key: a fresh load has priority over stepping.
  always_comb begin
    // NOTE: default assignment first so no path leaves k_d unassigned (no latch).
    k_d = k_q;
    if (load_i)      k_d = key_i;
    else if (step_i) k_d = key_update(k_q, rc_i);
  end

  // Key register, cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!reset) k_q <= '0;
    else        k_q <= k_d;
  end

  assign round_key_o = k_q[127:64];

endmodule

// File: rtl/present_encrypt_core.sv
// Iterative PRESENT-128 encryption, one round per clock. A load in IDLE or
// DONE starts a block; 31 rounds follow, then the final key whitening, and
// the result is held with load_encrypt high until the next accepted load.
module present_encrypt_core
  import present_pkg::*;
#(
  parameter int ROUNDS = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [BLOCK_W-1:0] plaintext,
  input  logic [KEY_W-1:0]   key,
  output logic [BLOCK_W-1:0] ciphertext,
  output logic               load_encrypt,
  output logic               busy
);

  state_e             state_q, state_d;
  logic [4:0]         rc_q, rc_d;
  logic [BLOCK_W-1:0] st_q, st_d;
  logic [BLOCK_W-1:0] ct_q, ct_d;
  logic [BLOCK_W-1:0] round_key;
  logic               accept;
  logic               step;

  // Loads are honoured only when no block is in flight.
  assign accept = load && (state_q == IDLE || state_q == DONE);
  assign step   = (state_q == RUN);

  present_key_schedule_128 u_key_schedule (
    .clk         (clk),
    .reset       (reset),
    .load_i      (accept),
    .step_i      (step),
    .key_i       (key),
    .rc_i        (rc_q),
    .round_key_o (round_key)
  );

  // Next-state, round datapath and output capture.
  always_comb begin
    state_d = state_q;
    rc_d    = rc_q;
    st_d    = st_q;
    ct_d    = ct_q;
    case (state_q)
      IDLE, DONE: begin
        if (accept) begin
          state_d = RUN;
          st_d    = plaintext;
          rc_d    = 5'd1;
        end
      end
      RUN: begin
        st_d = p_layer(sbox_layer(st_q ^ round_key));
        // The last round holds rc at ROUNDS so the 5-bit counter never wraps.
        if (rc_q == 5'(ROUNDS)) state_d = FINAL;
        else                    rc_d    = rc_q + 5'd1;
      end
      FINAL: begin
        ct_d    = st_q ^ round_key;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Core registers; reset aborts any operation immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      rc_q    <= '0;
      st_q    <= '0;
      ct_q    <= '0;
    end else begin
      state_q <= state_d;
      rc_q    <= rc_d;
      st_q    <= st_d;
      ct_q    <= ct_d;
    end
  end

  assign ciphertext   = ct_q;
  assign load_encrypt = (state_q == DONE);
  assign busy         = (state_q == RUN) || (state_q == FINAL);

endmodule
